gate_bank_fifo: RTL and testbench
=================================

Name: gate_bank_fifo

Overview:
Parametrised successor to the fixed quad 2-input AND chip model.
- N_CH independent 2-input gate channels, each WIDTH bits wide.
- One of eight bitwise operations is selected per transaction.
- Results are buffered in a DEPTH-entry output FIFO with valid/ready handshakes on both sides.
- Sits between lab datapath stimulus logic and downstream consumers, such as a display or checker, that may stall.

Parameters:
N_CH, 4, number of gate channels
WIDTH, 1, bits per channel operand
DEPTH, 4, output FIFO entries; must be a power of two and at least 2
CNT_W, 16, width of the completed-transaction counter

Ports:
i_clk  input  1  clock; all state updates on the rising edge
i_reset  input  1  asynchronous, active-high reset
i_valid  input  1  upstream presents a transaction
o_ready  output  1  block can accept a transaction this cycle
i_op  input  3  operation select, sampled on accept
i_a  input  N_CH*WIDTH  operand A; channel k occupies bits [k*WIDTH +: WIDTH]
i_b  input  N_CH*WIDTH  operand B; same packing as i_a
o_valid  output  1  FIFO head holds a result
i_ready  input  1  downstream accepts the head this cycle
o_y  output  N_CH*WIDTH  result at FIFO head
o_op  output  3  op code stored with the head entry
o_count  output  CNT_W  number of results popped; wraps modulo 2^CNT_W

Behaviour:
- Reset: i_reset high forces the FIFO empty, read/write pointers to 0 and o_count to 0.
  - Effect is immediate and independent of i_clk.
  - While in reset: o_valid=0, o_ready=0, o_y=0, o_op=0.
  - Reset asserted mid-stream discards every buffered entry; nothing is replayed.
- Op encoding:
  - 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 pass A, 111 NOT A.
  - Every code is legal; each operation is bitwise and independent per channel.
- Accept (push) occurs when i_valid && o_ready.
  - f(i_op, i_a, i_b) and i_op are written at the write pointer on that rising edge.
- o_ready = !full && !i_reset. There is no push-through when full, even if i_ready=1 in the same cycle.
- Pop occurs when o_valid && i_ready.
  - The read pointer advances and o_count increments by 1 on that edge.
- o_valid = !empty. o_y and o_op come straight from the storage entry at the read pointer (registered, no combinational path from i_a/i_b).
  - o_y and o_op are 0 when the FIFO is empty.
- Latency: a transaction accepted on edge k is visible on o_y with o_valid=1 in the cycle after edge k, provided the FIFO was empty.
- Throughput: one push and one pop per cycle are sustained.
- Pointers are log2(DEPTH)+1 bits.
  - Empty when the pointers are equal.
  - Full when the MSBs differ and the remaining bits are equal.
  - Wrap-around is natural modulo 2*DEPTH.
- Boundary conditions:
  - Simultaneous push and pop when neither empty nor full: occupancy unchanged, both pointers advance.
  - Empty with push and i_ready=1: push only, because o_valid is 0 in that cycle.
  - Full with i_valid=1 and i_ready=1: pop only; o_ready rises the next cycle.
- o_count wraps from 2^CNT_W-1 to 0 without saturating.
- Inputs are don't-care when i_valid=0. o_y/o_op hold steady while o_valid=1 and i_ready=0.

Optional Feature:
GATE_BANK_POPCNT_EN
- Defined:
  - Adds output o_ones, width $clog2(N_CH*WIDTH+1), equal to the number of 1 bits in o_y.
  - The count is computed at push time and stored alongside each entry, so it is registered and adds no combinational path on output.
  - o_ones=0 when the FIFO is empty or in reset.
- Undefined: the port and its storage are absent; all other behaviour is identical.

Test Plan:
All cases use N_CH=4, WIDTH=1, DEPTH=4.
1. Reset release, then push op=000, a=4'b1011, b=4'b0110 with i_ready=1 -> next cycle o_valid=1, o_y=4'b0010, o_op=000; after the pop, o_count=1 and o_valid=0.
2. All 8 ops with a=4'b1100, b=4'b1010, i_ready=1 -> o_y sequence 1000, 1110, 0110, 0111, 0001, 1001, 1100, 0011.
3. i_ready=0 with 5 back-to-back pushes -> o_ready falls after the 4th accept, the 5th is not taken and o_y holds the first result; raise i_ready -> 4 results drain in order, o_ready returns 1 after the first pop.
4. Continuous push with i_ready=1 for 20 cycles -> o_valid stays 1 from cycle 2, no entry lost or duplicated across pointer wrap, o_count=19 after the last full cycle.
5. Load 3 entries, assert i_reset asynchronously between clock edges -> o_valid, o_ready, o_y and o_count go to 0 immediately; after release, the FIFO is empty and the first new push appears alone.
6. With GATE_BANK_POPCNT_EN defined: push op=001, a=4'b0101, b=4'b0011 -> o_y=4'b0111, o_ones=3; with the FIFO empty, o_ones=0.

Source files
------------

// File: rtl/gate_bank_fifo.sv
// gate_bank_fifo: N_CH-channel bitwise gate bank (8 selectable ops) feeding a
// DEPTH-entry result FIFO with valid/ready handshakes on both sides.
// Optional feature macro: GATE_BANK_POPCNT_EN adds o_ones, the number of set
// bits in o_y. The count is computed at push time and stored with each entry.
module gate_bank_fifo #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [2:0]              i_op,
  input  logic [N_CH*WIDTH-1:0]   i_a,
  input  logic [N_CH*WIDTH-1:0]   i_b,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [N_CH*WIDTH-1:0]   o_y,
  output logic [2:0]              o_op,
`ifdef GATE_BANK_POPCNT_EN
  output logic [$clog2(N_CH*WIDTH+1)-1:0] o_ones,
`endif
  output logic [CNT_W-1:0]        o_count
);

  localparam int unsigned DW     = N_CH * WIDTH;
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned PW     = AW + 1;
`ifdef GATE_BANK_POPCNT_EN
  localparam int unsigned ONES_W = $clog2(DW + 1);
`endif

  // Op codes: every 3-bit value is a legal operation.
  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_PASS = 3'b110;
  localparam logic [2:0] OP_NOTA = 3'b111;

  logic [DW-1:0] y_mem  [DEPTH];
  logic [2:0]    op_mem [DEPTH];
`ifdef GATE_BANK_POPCNT_EN
  logic [ONES_W-1:0] ones_mem [DEPTH];
  logic [ONES_W-1:0] ones_c;
`endif

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CNT_W-1:0] pop_cnt;
  logic [DW-1:0]    y_c;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;

  // Pointer comparison: equal means empty, MSB-only difference means full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign o_ready = !full && !i_reset;
  assign o_valid = !empty;
  assign push    = i_valid && o_ready;
  assign pop     = o_valid && i_ready;

  // Bitwise gate function; channels are independent since every op is bitwise.
  always_comb begin
    y_c = '0;
    case (i_op)
      OP_AND:  y_c = i_a & i_b;
      OP_OR:   y_c = i_a | i_b;
      OP_XOR:  y_c = i_a ^ i_b;
      OP_NAND: y_c = ~(i_a & i_b);
      OP_NOR:  y_c = ~(i_a | i_b);
      OP_XNOR: y_c = ~(i_a ^ i_b);
      OP_PASS: y_c = i_a;
      OP_NOTA: y_c = ~i_a;
      default: y_c = '0;
    endcase
  end

`ifdef GATE_BANK_POPCNT_EN
  // Set-bit count of the result, captured with the entry at push time.
  always_comb begin
    ones_c = '0;
    for (int i = 0; i < int'(DW); i++) begin
      ones_c = ones_c + ONES_W'(y_c[i]);
    end
  end
`endif

  // Entry storage; contents need no reset because empty masks the head.
  always_ff @(posedge i_clk) begin
    if (push) begin
      y_mem[wr_ptr[AW-1:0]]    <= y_c;
      op_mem[wr_ptr[AW-1:0]]   <= i_op;
`ifdef GATE_BANK_POPCNT_EN
      ones_mem[wr_ptr[AW-1:0]] <= ones_c;
`endif
    end
  end

  // Write pointer advances on every accepted transaction.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PW'(1);
    end
  end

  // Read pointer and completed-transaction counter advance on every pop.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rd_ptr  <= '0;
      pop_cnt <= '0;
    end else if (pop) begin
      rd_ptr  <= rd_ptr + PW'(1);
      pop_cnt <= pop_cnt + CNT_W'(1);
    end
  end

  // Head entry, forced to zero while the FIFO is empty (including reset).
  assign o_y     = empty ? '0 : y_mem[rd_ptr[AW-1:0]];
  assign o_op    = empty ? '0 : op_mem[rd_ptr[AW-1:0]];
`ifdef GATE_BANK_POPCNT_EN
  assign o_ones  = empty ? '0 : ones_mem[rd_ptr[AW-1:0]];
`endif
  assign o_count = pop_cnt;

endmodule

// File: tb/tb_gate_bank_fifo.sv
// Scoreboard bench for gate_bank_fifo (N_CH=4, WIDTH=1, DEPTH=4, CNT_W=16).
// Define GATE_BANK_POPCNT_EN on both files to exercise o_ones.
module tb_gate_bank_fifo;

  logic        i_clk   = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b0;
  logic [2:0]  i_op    = '0;
  logic [3:0]  i_a     = '0;
  logic [3:0]  i_b     = '0;
  logic        o_ready;
  logic        o_valid;
  logic [3:0]  o_y;
  logic [2:0]  o_op;
  logic [15:0] o_count;
`ifdef GATE_BANK_POPCNT_EN
  logic [2:0]  o_ones;
`endif

  typedef struct packed {
    logic [3:0] y;
    logic [2:0] op;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  // Results for a=1100, b=1010 under ops 0..7.
  logic [3:0] tab_y [8] = '{4'b1000, 4'b1110, 4'b0110, 4'b0111,
                            4'b0001, 4'b1001, 4'b1100, 4'b0011};

  gate_bank_fifo #(.N_CH(4), .WIDTH(1), .DEPTH(4), .CNT_W(16)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_op    (i_op),
    .i_a     (i_a),
    .i_b     (i_b),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_y     (o_y),
    .o_op    (o_op),
`ifdef GATE_BANK_POPCNT_EN
    .o_ones  (o_ones),
`endif
    .o_count (o_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: a pop will happen on the next rising edge; compare against the queue head.
  always @(negedge i_clk) begin
    if (!i_reset && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pop: got y=%b op=%b, required no entry", o_y, o_op);
      end else begin
        mon_e = exp_q.pop_front();
        check("pop_y", 32'(o_y), 32'(mon_e.y));
        check("pop_op", 32'(o_op), 32'(mon_e.op));
`ifdef GATE_BANK_POPCNT_EN
        check("pop_ones", 32'(o_ones), 32'($countones(mon_e.y)));
`endif
      end
    end
  end

  // One transaction offer; called just after a rising edge, returns just after the next.
  task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] y, input logic rdy);
    i_valid = 1'b1;
    i_op    = op;
    i_a     = a;
    i_b     = b;
    @(negedge i_clk);
    check("o_ready", 32'(o_ready), 32'(rdy));
    if (rdy) exp_q.push_back('{y: y, op: op});
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // Reset state
    #3;
    check("rst_valid", 32'(o_valid), 0);
    check("rst_ready", 32'(o_ready), 0);
    check("rst_y", 32'(o_y), 0);
    check("rst_op", 32'(o_op), 0);
    check("rst_count", 32'(o_count), 0);
    @(negedge i_clk);
    i_reset = 1'b0;
    @(posedge i_clk);
    #1;

    // 1: single AND, one-cycle latency, then pop
    i_ready = 1'b1;
    send(3'b000, 4'b1011, 4'b0110, 4'b0010, 1'b1);
    check("t1_valid", 32'(o_valid), 1);
    check("t1_y", 32'(o_y), 32'(4'b0010));
    idle(1);
    check("t1_valid_after", 32'(o_valid), 0);
    check("t1_count", 32'(o_count), 1);

    // 2: all eight ops back to back
    for (int k = 0; k < 8; k++) send(3'(k), 4'b1100, 4'b1010, tab_y[k], 1'b1);
    idle(2);
    check("t2_drained", 32'(exp_q.size()), 0);
    check("t2_count", 32'(o_count), 9);

    // 3: stall, fill, refused 5th, then pop-only while full
    i_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(3'(k), 4'b1100, 4'b1010, tab_y[k], 1'b1);
    send(3'b100, 4'b1100, 4'b1010, 4'b0001, 1'b0);
    check("t3_hold_valid", 32'(o_valid), 1);
    check("t3_hold_y", 32'(o_y), 32'(4'b1000));
    check("t3_hold_op", 32'(o_op), 0);
    i_ready = 1'b1;
    send(3'b100, 4'b1100, 4'b1010, 4'b0001, 1'b0);
    check("t3_ready_back", 32'(o_ready), 1);
    idle(4);
    check("t3_empty", 32'(o_valid), 0);
    check("t3_count", 32'(o_count), 13);

    // 4: 20 back-to-back pushes with concurrent pops across pointer wrap
    i_reset = 1'b1;
    #1;
    i_reset = 1'b0;
    check("t4_count0", 32'(o_count), 0);
    for (int k = 0; k < 20; k++) begin
      if (k > 0) check("t4_valid", 32'(o_valid), 1);
      send(3'(k % 8), 4'b1100, 4'b1010, tab_y[k % 8], 1'b1);
    end
    check("t4_count", 32'(o_count), 19);
    idle(2);
    check("t4_drained", 32'(exp_q.size()), 0);
    check("t4_empty", 32'(o_valid), 0);

    // 5: async reset between edges discards buffered entries
    i_ready = 1'b0;
    send(3'b000, 4'b1111, 4'b1111, 4'b1111, 1'b1);
    send(3'b001, 4'b0001, 4'b0010, 4'b0011, 1'b1);
    send(3'b110, 4'b0101, 4'b0000, 4'b0101, 1'b1);
    #2;
    i_reset = 1'b1;
    exp_q.delete();
    #1;
    check("t5_rst_valid", 32'(o_valid), 0);
    check("t5_rst_ready", 32'(o_ready), 0);
    check("t5_rst_y", 32'(o_y), 0);
    check("t5_rst_count", 32'(o_count), 0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    @(posedge i_clk);
    #1;
    check("t5_post_empty", 32'(o_valid), 0);
    i_ready = 1'b1;
    send(3'b010, 4'b0101, 4'b0011, 4'b0110, 1'b1);
    check("t5_new_valid", 32'(o_valid), 1);
    check("t5_new_y", 32'(o_y), 32'(4'b0110));
    idle(1);
    check("t5_alone", 32'(o_valid), 0);
    check("t5_count", 32'(o_count), 1);

`ifdef GATE_BANK_POPCNT_EN
    // 6: set-bit count travels with the entry
    send(3'b001, 4'b0101, 4'b0011, 4'b0111, 1'b1);
    check("t6_ones", 32'(o_ones), 3);
    idle(1);
    check("t6_ones_empty", 32'(o_ones), 0);
`endif

    // Bounded final drain
    begin
      int budget;
      budget = 20;
      while (exp_q.size() != 0 && budget > 0) begin
        idle(1);
        budget--;
      end
      check("final_drained", 32'(exp_q.size()), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
